// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - stage indices and hold FSM state type shared by the pipeline controller
package pipe_ctrl_pkg;

    // Stage indices of the default 5-stage in-order pipeline
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam int DEF_NUM_STAGES = STG_WB + 1;
    localparam int DEF_CNT_W      = 4;

    // Timed-hold controller states
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hold_state_e;

endpackage

// File: rtl/pipe_hold_fsm.sv
// rtl/pipe_hold_fsm.sv - timed multi-cycle hold sequencer producing a one-hot hold vector
module pipe_hold_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SIDX_W     = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold_req,
    input  logic [SIDX_W-1:0]     hold_stage,
    input  logic [CNT_W-1:0]      hold_cycles,
    input  logic [SIDX_W-1:0]     flush_src,
    output logic                  hold_ack,
    output logic                  hold_done,
    output logic                  hold_abort,
    output logic [NUM_STAGES-1:0] hold_vec
);

    hold_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIDX_W-1:0] stage_q, stage_d;

    logic [SIDX_W-1:0] req_stage;
    logic              vec_active;
    logic [SIDX_W-1:0] vec_stage;

    // Out-of-range stage numbers collapse onto the last stage (WB)
    assign req_stage = ({1'b0, hold_stage} >= (SIDX_W+1)'(NUM_STAGES))
                     ? SIDX_W'(NUM_STAGES - 1) : hold_stage;

    // State, remaining-cycle count and held stage; reset drops any pending hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
        end
    end

    // Next state and the ack/done/abort pulses; the first hold cycle is the ack cycle itself
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stage_d    = stage_q;
        hold_ack   = 1'b0;
        hold_done  = 1'b0;
        hold_abort = 1'b0;
        vec_active = 1'b0;
        vec_stage  = stage_q;
        case (state_q)
            IDLE: begin
                // A request whose stage is about to be flushed is refused outright;
                // rst_n gating keeps pulses quiet while reset is asserted.
                if (rst_n && hold_req && (hold_cycles != '0) && !(flush_src > req_stage)) begin
                    hold_ack   = 1'b1;
                    vec_active = 1'b1;
                    vec_stage  = req_stage;
                    if (hold_cycles == CNT_W'(1)) begin
                        hold_done = 1'b1;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = hold_cycles - CNT_W'(1);
                        stage_d = req_stage;
                    end
                end
            end
            HOLD: begin
                // A redirect from a younger-fetched stage kills the held instruction
                if (flush_src > stage_q) begin
                    hold_abort = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = '0;
                end else begin
                    vec_active = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        hold_done = 1'b1;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // One-hot decode of the held stage
    always_comb begin
        hold_vec = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            hold_vec[i] = vec_active && (vec_stage == SIDX_W'(i));
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - N-stage stall/flush controller; perf counters built only with PIPE_CTRL_PERF_EN
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SIDX_W     = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic [NUM_STAGES-1:0] flush_req,
    input  logic                  hold_req,
    input  logic [SIDX_W-1:0]     hold_stage,
    input  logic [CNT_W-1:0]      hold_cycles,
    output logic                  hold_ack,
    output logic                  hold_done,
    output logic                  hold_abort,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
);

    logic [SIDX_W-1:0]     flush_src;
    logic [NUM_STAGES-1:0] hold_vec;

    // Highest requesting stage is the flush source; flush_req[0] alone kills nothing
    always_comb begin
        flush_src = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (flush_req[i]) begin
                flush_src = SIDX_W'(i);
            end
        end
    end

    pipe_hold_fsm #(
        .NUM_STAGES (NUM_STAGES),
        .CNT_W      (CNT_W),
        .SIDX_W     (SIDX_W)
    ) u_hold_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold_req    (hold_req),
        .hold_stage  (hold_stage),
        .hold_cycles (hold_cycles),
        .flush_src   (flush_src),
        .hold_ack    (hold_ack),
        .hold_done   (hold_done),
        .hold_abort  (hold_abort),
        .hold_vec    (hold_vec)
    );

    // Thermometer stall from the top down; a flushed stage is never also stalled
    always_comb begin
        logic acc;
        acc   = 1'b0;
        flush = '0;
        stall = '0;
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            acc      = acc | stall_req[j] | hold_vec[j];
            flush[j] = SIDX_W'(j) < flush_src;
            stall[j] = acc & ~flush[j];
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Saturating event counters
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall[0] && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if ((|flush) && (perf_flush_q != 32'hFFFF_FFFF)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a cycle-level behavioural model
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  stall_req;
    logic [4:0]  flush_req;
    logic        hold_req;
    logic [2:0]  hold_stage;
    logic [3:0]  hold_cycles;
    logic        hold_ack;
    logic        hold_done;
    logic        hold_abort;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    int vectors    = 0;
    int miscompares = 0;

    // Model state: cycles of the current hold still to come, held stage, perf counts
    int          m_rem  = 0;
    int          m_stg  = 0;
    logic [31:0] m_pstall = 0;
    logic [31:0] m_pflush = 0;

    pipe_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_req      (stall_req),
        .flush_req      (flush_req),
        .hold_req       (hold_req),
        .hold_stage     (hold_stage),
        .hold_cycles    (hold_cycles),
        .hold_ack       (hold_ack),
        .hold_done      (hold_done),
        .hold_abort     (hold_abort),
        .stall          (stall),
        .flush          (flush),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, compare against the model, then clock and compare counters
    task automatic apply(input string tag, input logic [4:0] sr, input logic [4:0] fr,
                         input logic hr, input logic [2:0] hs, input logic [3:0] hc);
        int f, vec, new_rem, stg;
        logic [4:0] es, ef;
        logic ea, ed, eab, act;
        stall_req   = sr;
        flush_req   = fr;
        hold_req    = hr;
        hold_stage  = hs;
        hold_cycles = hc;
        #1;
        f = -1;
        for (int i = 0; i < 5; i++) if (fr[i]) f = i;
        vec = -1; ea = 0; ed = 0; eab = 0; new_rem = m_rem;
        if (m_rem > 0) begin
            if (f > m_stg) begin
                eab = 1; new_rem = 0;
            end else begin
                vec = m_stg; new_rem = m_rem - 1; ed = (new_rem == 0);
            end
        end else if (hr && hc != 0) begin
            stg = (hs > 4) ? 4 : int'(hs);
            if (!(f > stg)) begin
                ea = 1; vec = stg; m_stg = stg;
                new_rem = int'(hc) - 1; ed = (new_rem == 0);
            end
        end
        for (int j = 0; j < 5; j++) begin
            act = 0;
            for (int k = j; k < 5; k++) if (sr[k] || vec == k) act = 1;
            ef[j] = (j < f);
            es[j] = act && !ef[j];
        end
        check({tag, "_stall"}, 32'(stall), 32'(es));
        check({tag, "_flush"}, 32'(flush), 32'(ef));
        check({tag, "_ack"},   32'(hold_ack), 32'(ea));
        check({tag, "_done"},  32'(hold_done), 32'(ed));
        check({tag, "_abort"}, 32'(hold_abort), 32'(eab));
        @(posedge clk);
        m_rem = new_rem;
        if (PERF_EN && es[0]) m_pstall = m_pstall + 1;
        if (PERF_EN && (|ef)) m_pflush = m_pflush + 1;
        #2;
        check({tag, "_pstall"}, perf_stall_cnt, m_pstall);
        check({tag, "_pflush"}, perf_flush_cnt, m_pflush);
    endtask

    task automatic model_reset();
        m_rem = 0; m_pstall = 0; m_pflush = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        stall_req = '0; flush_req = '0; hold_req = 1'b0; hold_stage = '0; hold_cycles = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_ack",   32'(hold_ack), 32'd0);
        check("rst_pstall", perf_stall_cnt, 32'd0);
        check("rst_pflush", perf_flush_cnt, 32'd0);
        rst_n = 1'b1;

        // Thermometer stall and flush-beats-stall
        apply("therm",  5'b00100, 5'b00000, 0, 3'd0, 4'd0);
        apply("flush",  5'b00010, 5'b00100, 0, 3'd0, 4'd0);
        apply("multi",  5'b01001, 5'b10010, 0, 3'd0, 4'd0);

        // Hold stage 3 for 4 cycles, requester keeps asserting
        for (int c = 0; c < 4; c++) apply("hold4", 5'b00000, 5'b00000, 1, 3'd3, 4'd4);
        apply("hold4_end", 5'b00000, 5'b00000, 0, 3'd0, 4'd0);

        // Hold stage 1 for 6 cycles, aborted by flush from stage 2 in cycle 2
        apply("ab0", 5'b00000, 5'b00000, 1, 3'd1, 4'd6);
        apply("ab1", 5'b00000, 5'b00000, 1, 3'd1, 4'd6);
        apply("ab2", 5'b00000, 5'b00100, 1, 3'd1, 4'd6);
        apply("ab3", 5'b00000, 5'b00000, 0, 3'd0, 4'd0);

        // Hold stage 3 for 3 cycles survives an older-stage flush
        apply("cont0", 5'b00000, 5'b00000, 1, 3'd3, 4'd3);
        apply("cont1", 5'b00000, 5'b00100, 0, 3'd3, 4'd3);
        apply("cont2", 5'b00000, 5'b00000, 0, 3'd3, 4'd3);
        apply("cont3", 5'b00000, 5'b00000, 0, 3'd0, 4'd0);

        // Zero-length, single-cycle, refused-by-flush and clamped-stage requests
        apply("zero",   5'b00000, 5'b00000, 1, 3'd2, 4'd0);
        apply("one",    5'b00000, 5'b00000, 1, 3'd2, 4'd1);
        apply("refuse", 5'b00000, 5'b01000, 1, 3'd1, 4'd3);
        apply("clamp0", 5'b00000, 5'b00000, 1, 3'd7, 4'd2);
        apply("clamp1", 5'b00000, 5'b00000, 0, 3'd0, 4'd0);
        apply("idle",   5'b00000, 5'b00000, 0, 3'd0, 4'd0);

        // Asynchronous reset in the middle of a hold of 8
        apply("rh0", 5'b00000, 5'b00000, 1, 3'd2, 4'd8);
        apply("rh1", 5'b00000, 5'b00000, 0, 3'd2, 4'd8);
        stall_req = 5'b00001; hold_req = 1'b1; hold_cycles = 4'd3;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rstmid_stall", 32'(stall), 32'b00001);
        check("rstmid_ack",   32'(hold_ack), 32'd0);
        check("rstmid_done",  32'(hold_done), 32'd0);
        check("rstmid_pstall", perf_stall_cnt, 32'd0);
        @(posedge clk);
        #2;
        hold_req = 1'b0;
        rst_n = 1'b1;
        apply("rh_after", 5'b00000, 5'b00000, 0, 3'd0, 4'd0);

        // Perf scenario from a fresh reset: 10 stall cycles then 3 flush pulses
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) apply("pst", 5'b00001, 5'b00000, 0, 3'd0, 4'd0);
        for (int c = 0; c < 3; c++)  apply("pfl", 5'b00000, 5'b00010, 0, 3'd0, 4'd0);
        check("perf_stall_10", perf_stall_cnt, PERF_EN ? 32'd10 : 32'd0);
        check("perf_flush_3",  perf_flush_cnt, PERF_EN ? 32'd3 : 32'd0);

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            logic [4:0] sr, fr;
            logic       hr;
            sr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            fr = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            hr = ($urandom_range(0, 2) == 0);
            apply("rnd", sr, fr, hr, 3'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
